audio_gain_ramp: RTL

AUDIO_GAIN_RAMP -- requirements
Module: audio_gain_ramp

---
 rtl/audio_gain_ramp_pkg.sv | 17 +
 rtl/sample_scale_sat.sv | 61 ++++++
 rtl/audio_gain_ramp.sv | 100 ++++++++++
 3 files changed

// File: rtl/audio_gain_ramp_pkg.sv
// Shared audio definitions: default widths, unity gain and ramp-state encoding.
package audio_gain_ramp_pkg;

    localparam int DEF_DATA_W   = 24;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_GAIN_W   = 8;

    // Gain is a fixed-point value with GAIN_W-1 fractional bits.
    localparam logic [DEF_GAIN_W-1:0] UNITY_GAIN = 8'd128;

    typedef enum logic [1:0] {
        StSteady   = 2'd0,
        StRampUp   = 2'd1,
        StRampDown = 2'd2
    } ramp_state_e;

endpackage

// File: rtl/sample_scale_sat.sv
// One channel of the gain datapath: registered multiply, then registered
// arithmetic shift with saturation and a clip flag.
module sample_scale_sat #(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic [DATA_W-1:0] result_o,
    output logic              clip_o
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    localparam logic signed [PROD_W-1:0] MAX_V =
        {{(PROD_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] MIN_V =
        {{(PROD_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] shifted;
    logic [DATA_W-1:0]        result_d;
    logic                     clip_d;

    // Signed sample times zero-extended gain, then floor-shift and clamp.
    always_comb begin
        sample_ext = {{(GAIN_W + 1){sample_i[DATA_W-1]}}, sample_i};
        gain_ext   = {{(DATA_W + 1){1'b0}}, gain_i};
        prod_d     = sample_ext * gain_ext;
        shifted    = prod_q >>> (GAIN_W - 1);
        result_d   = shifted[DATA_W-1:0];
        clip_d     = 1'b0;
        if (shifted > MAX_V) begin
            result_d = MAX_V[DATA_W-1:0];
            clip_d   = 1'b1;
        end else if (shifted < MIN_V) begin
            result_d = MIN_V[DATA_W-1:0];
            clip_d   = 1'b1;
        end
    end

    // Both stages advance together under the global stall enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q   <= '0;
            result_o <= '0;
            clip_o   <= 1'b0;
        end else if (en_i) begin
            prod_q   <= prod_d;
            result_o <= result_d;
            clip_o   <= clip_d;
        end
    end

endmodule

// File: rtl/audio_gain_ramp.sv
// Multichannel gain stage with a pop-free gain ramp and valid/ready handshake.
module audio_gain_ramp
    import audio_gain_ramp_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int GAIN_W    = DEF_GAIN_W,
    parameter int RAMP_STEP = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [GAIN_W-1:0]          gain_target,
    input  logic                       mute,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic [CHANNELS-1:0]        clip,
    output logic [GAIN_W-1:0]          gain_current
);

    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    ramp_state_e       state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W-1:0] target;
    logic [GAIN_W-1:0] diff;
    logic              valid1_q;
    logic              out_valid_q;
    logic              advance;
    logic              accept;

    assign advance      = out_ready | ~out_valid_q;
    assign in_ready     = advance;
    assign accept       = in_valid & advance;
    assign out_valid    = out_valid_q;
    assign gain_current = gain_q;

    // Pipeline valid bits follow the datapath under the same stall.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            valid1_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            valid1_q    <= in_valid;
            out_valid_q <= valid1_q;
        end
    end

    // Ramp decision on each accepted frame; the step is clamped to the target.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        target  = mute ? '0 : gain_target;
        diff    = '0;
        if (accept) begin
            if (gain_q < target) begin
                state_d = StRampUp;
                diff    = target - gain_q;
                gain_d  = (diff > STEP) ? gain_q + STEP : target;
            end else if (gain_q > target) begin
                state_d = StRampDown;
                diff    = gain_q - target;
                gain_d  = (diff > STEP) ? gain_q - STEP : target;
            end else begin
                state_d = StSteady;
            end
        end
    end

    // Ramp state and current gain register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StSteady;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Each channel is scaled with the gain held before this frame's update.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        sample_scale_sat #(
            .DATA_W(DATA_W),
            .GAIN_W(GAIN_W)
        ) u_scale (
            .clk_i   (CLOCK_50),
            .rst_i   (reset),
            .en_i    (advance),
            .sample_i(in_data[k*DATA_W +: DATA_W]),
            .gain_i  (gain_q),
            .result_o(out_data[k*DATA_W +: DATA_W]),
            .clip_o  (clip[k])
        );
    end

endmodule
